// File: rtl/phase_checker.sv
// rtl/phase_checker.sv - receiver-side checker for the 4-bit one-hot phase ring
//
// Samples the sequencer's phase vector every cycle, checks each ph_q -> ph
// transition against the ring protocol, counts completed rounds and latches
// the first protocol fault for debug readout.
//
// Ports:
//   CLK        clock, rising edge
//   RSTN       asynchronous active-low reset
//   ph         phase vector from the sequencer (one-hot or 0000)
//   clr        synchronous clear of counters, faults and sync state
//   phase_idx  binary index of the sampled phase (0 when idle)
//   running    1 while a legal nonzero phase is being tracked
//   round_cnt  completed-round count (wraps)
//   round_done one-cycle pulse per completed round
//   stopped    one-cycle pulse on 1000 -> 0000
//   ovf        sticky, round_cnt wrapped
//   err        sticky, protocol fault seen
//   err_code   first fault cause: 01 illegal value, 10 illegal transition
//   err_ph     ph value that caused the first fault
module phase_checker #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [3:0]       ph,
  input  logic             clr,
  output logic [1:0]       phase_idx,
  output logic             running,
  output logic [CNT_W-1:0] round_cnt,
  output logic             round_done,
  output logic             stopped,
  output logic             ovf,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [3:0]       err_ph
);

  typedef enum logic [1:0] {SYNC, IDLE, RUN, FAULT} state_t;

  localparam logic [1:0] CODE_VAL = 2'b01;
  localparam logic [1:0] CODE_TR  = 2'b10;

  state_t     state;
  logic [3:0] ph_q;

  logic       ph_legal;
  logic [1:0] ph_idx;
  logic       trans_ok;
  logic       fault;
  logic [1:0] fault_code;
  logic       round_evt;

  always_comb begin
    ph_legal = 1'b1;
    ph_idx   = 2'd0;
    case (ph)
      4'b0000: ph_idx = 2'd0;
      4'b0001: ph_idx = 2'd0;
      4'b0010: ph_idx = 2'd1;
      4'b0100: ph_idx = 2'd2;
      4'b1000: ph_idx = 2'd3;
      default: ph_legal = 1'b0;
    endcase
  end

  always_comb begin
    case ({ph_q, ph})
      {4'b0000, 4'b0000},
      {4'b0000, 4'b0001},
      {4'b0001, 4'b0010},
      {4'b0010, 4'b0100},
      {4'b0100, 4'b1000},
      {4'b1000, 4'b0001},
      {4'b1000, 4'b0000}: trans_ok = 1'b1;
      default:            trans_ok = 1'b0;
    endcase
  end

  // Illegal value is reported ahead of an illegal transition. SYNC skips the
  // transition check so a preloaded sequencer is accepted after reset/clr.
  always_comb begin
    fault      = 1'b0;
    fault_code = 2'b00;
    case (state)
      SYNC: begin
        if (!ph_legal) begin
          fault      = 1'b1;
          fault_code = CODE_VAL;
        end
      end
      IDLE, RUN: begin
        if (!ph_legal) begin
          fault      = 1'b1;
          fault_code = CODE_VAL;
        end else if (!trans_ok) begin
          fault      = 1'b1;
          fault_code = CODE_TR;
        end
      end
      default: ;
    endcase
  end

  // Only RUN can hold ph_q = 1000, so a legal exit from 1000 is a round.
  assign round_evt = (state == RUN) && !fault && (ph_q == 4'b1000);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= SYNC;
      ph_q       <= 4'b0000;
      phase_idx  <= 2'd0;
      running    <= 1'b0;
      round_cnt  <= '0;
      round_done <= 1'b0;
      stopped    <= 1'b0;
      ovf        <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
      err_ph     <= 4'b0000;
    end else if (clr) begin
      state      <= SYNC;
      ph_q       <= 4'b0000;
      phase_idx  <= 2'd0;
      running    <= 1'b0;
      round_cnt  <= '0;
      round_done <= 1'b0;
      stopped    <= 1'b0;
      ovf        <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
      err_ph     <= 4'b0000;
    end else begin
      ph_q       <= ph;
      phase_idx  <= ph_idx;
      round_done <= 1'b0;
      stopped    <= 1'b0;
      if (state == FAULT) begin
        running <= 1'b0;
      end else if (fault) begin
        // Entering FAULT is by construction the first fault since clr/reset.
        state    <= FAULT;
        running  <= 1'b0;
        err      <= 1'b1;
        err_code <= fault_code;
        err_ph   <= ph;
      end else begin
        if (ph == 4'b0000) begin
          state   <= IDLE;
          running <= 1'b0;
        end else begin
          state   <= RUN;
          running <= 1'b1;
        end
        if (round_evt) begin
          round_cnt  <= round_cnt + 1'b1;
          round_done <= 1'b1;
          stopped    <= (ph == 4'b0000);
          if (&round_cnt) ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_phase_checker.sv
// tb/tb_phase_checker.sv - scoreboard bench for phase_checker
module tb_phase_checker;

  localparam int CNT_W = 4;

  logic             CLK;
  logic             RSTN;
  logic [3:0]       ph;
  logic             clr;
  logic [1:0]       phase_idx;
  logic             running;
  logic [CNT_W-1:0] round_cnt;
  logic             round_done;
  logic             stopped;
  logic             ovf;
  logic             err;
  logic [1:0]       err_code;
  logic [3:0]       err_ph;

  phase_checker #(.CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .ph        (ph),
    .clr       (clr),
    .phase_idx (phase_idx),
    .running   (running),
    .round_cnt (round_cnt),
    .round_done(round_done),
    .stopped   (stopped),
    .ovf       (ovf),
    .err       (err),
    .err_code  (err_code),
    .err_ph    (err_ph)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0]       idx;
    logic             run;
    logic [CNT_W-1:0] cnt;
    logic             rd;
    logic             st;
    logic             ovf;
    logic             err;
    logic [1:0]       code;
    logic [3:0]       eph;
  } exp_t;

  exp_t sb_q[$];

  int n_total  = 0;
  int n_passed = 0;

  // Reference model: protocol described as a set of legal sample pairs.
  logic [3:0] legal_pairs [7][2];
  bit         m_sync;
  bit         m_fault;
  logic [3:0] m_prev;
  int         m_cnt;
  bit         m_ovf;
  exp_t       m_out;

  initial begin
    legal_pairs[0][0] = 4'h0; legal_pairs[0][1] = 4'h0;
    legal_pairs[1][0] = 4'h0; legal_pairs[1][1] = 4'h1;
    legal_pairs[2][0] = 4'h1; legal_pairs[2][1] = 4'h2;
    legal_pairs[3][0] = 4'h2; legal_pairs[3][1] = 4'h4;
    legal_pairs[4][0] = 4'h4; legal_pairs[4][1] = 4'h8;
    legal_pairs[5][0] = 4'h8; legal_pairs[5][1] = 4'h1;
    legal_pairs[6][0] = 4'h8; legal_pairs[6][1] = 4'h0;
  end

  function automatic bit is_legal(input logic [3:0] v);
    return (v == 4'h0) || (v == 4'h1) || (v == 4'h2) || (v == 4'h4) || (v == 4'h8);
  endfunction

  function automatic bit pair_ok(input logic [3:0] a, input logic [3:0] b);
    for (int i = 0; i < 7; i++)
      if (legal_pairs[i][0] == a && legal_pairs[i][1] == b) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] index_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v == (4'h1 << i)) return 2'(i);
    return 2'd0;
  endfunction

  task automatic model_clear();
    m_sync  = 1'b1;
    m_fault = 1'b0;
    m_prev  = 4'h0;
    m_cnt   = 0;
    m_ovf   = 1'b0;
    m_out   = '0;
  endtask

  task automatic model_edge(input logic [3:0] p, input logic c, input logic r);
    bit bad_val;
    bit bad_tr;
    if (!r || c) begin
      model_clear();
    end else begin
      bad_val    = !is_legal(p);
      bad_tr     = !m_sync && !pair_ok(m_prev, p);
      m_out.rd   = 1'b0;
      m_out.st   = 1'b0;
      m_out.idx  = index_of(p);
      if (!m_fault) begin
        if (bad_val || bad_tr) begin
          m_fault    = 1'b1;
          m_out.err  = 1'b1;
          m_out.code = bad_val ? 2'b01 : 2'b10;
          m_out.eph  = p;
        end else begin
          if (!m_sync && m_prev == 4'h8) begin
            m_out.rd = 1'b1;
            m_out.st = (p == 4'h0);
            if (m_cnt == (1 << CNT_W) - 1) m_ovf = 1'b1;
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
          end
          m_sync = 1'b0;
        end
      end
      m_out.run = !m_fault && (p != 4'h0);
      m_out.cnt = CNT_W'(m_cnt);
      m_out.ovf = m_ovf;
      m_prev    = p;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act !== exp_v)
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp_v, $time);
    else
      n_passed++;
  endtask

  // Monitor: every cycle the DUT presents a fresh registered output set.
  always @(negedge CLK) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("phase_idx",  32'(phase_idx),  32'(e.idx));
      chk("running",    32'(running),    32'(e.run));
      chk("round_cnt",  32'(round_cnt),  32'(e.cnt));
      chk("round_done", 32'(round_done), 32'(e.rd));
      chk("stopped",    32'(stopped),    32'(e.st));
      chk("ovf",        32'(ovf),        32'(e.ovf));
      chk("err",        32'(err),        32'(e.err));
      chk("err_code",   32'(err_code),   32'(e.code));
      chk("err_ph",     32'(err_ph),     32'(e.eph));
    end
  end

  task automatic step(input logic [3:0] p, input logic c, input logic r);
    @(negedge CLK);
    #1;
    ph   = p;
    clr  = c;
    RSTN = r;
    @(posedge CLK);
    model_edge(p, c, r);
    sb_q.push_back(m_out);
  endtask

  task automatic go(input logic [3:0] p);
    step(p, 1'b0, 1'b1);
  endtask

  task automatic ring_round(input logic [3:0] last);
    go(4'h2); go(4'h4); go(4'h8); go(last);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] nxt;
    RSTN = 1'b0;
    ph   = 4'h0;
    clr  = 1'b0;
    model_clear();

    // reset state
    repeat (3) step(4'h0, 1'b0, 1'b0);

    // first round
    repeat (3) go(4'h0);
    go(4'h1); go(4'h2); go(4'h4); go(4'h8); go(4'h1);

    // five more rounds, the last one stopping
    for (int k = 0; k < 5; k++) ring_round((k < 4) ? 4'h1 : 4'h0);
    repeat (2) go(4'h0);

    // skipped phase, then a later fault that must not overwrite the first
    go(4'h1); go(4'h4); go(4'h3); go(4'h8); go(4'h1);

    // illegal value from IDLE, clr, then preloaded phase accepted
    step(4'h0, 1'b1, 1'b1);
    go(4'h0); go(4'h0); go(4'h6); go(4'h0);
    step(4'h0, 1'b1, 1'b1);
    go(4'h2); go(4'h4); go(4'h8); go(4'h0);

    // counter wrap, then clr colliding with a round completion
    step(4'h0, 1'b1, 1'b1);
    go(4'h1);
    repeat (16) ring_round(4'h1);
    go(4'h2); go(4'h4); go(4'h8);
    step(4'h1, 1'b1, 1'b1);
    go(4'h0);

    // reset mid-run with a preloaded phase
    go(4'h1); go(4'h2); go(4'h4);
    step(4'h4, 1'b0, 1'b0);
    step(4'h4, 1'b0, 1'b0);
    go(4'h4); go(4'h8); go(4'h1); go(4'h2);

    // randomized traffic around the ring with injected faults, clr and reset
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        step(4'(1 << $urandom_range(0, 3)), 1'b0, 1'b0);
      end else if ($urandom_range(0, 39) == 0 || (m_fault && $urandom_range(0, 7) == 0)) begin
        step(4'($urandom_range(0, 15)), 1'b1, 1'b1);
      end else begin
        if ($urandom_range(0, 29) == 0)
          nxt = 4'($urandom_range(0, 15));
        else if (m_prev == 4'h0 || m_prev == 4'h8)
          nxt = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'h1;
        else if (is_legal(m_prev))
          nxt = m_prev << 1;
        else
          nxt = 4'h0;
        go(nxt);
      end
    end
    go(4'h0);

    repeat (3) @(negedge CLK);
    #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
